// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - decode-stage hazard detection and forwarding-select unit
// Optional macro HAZARD_PERF_EN enables the stall/flush perf counters.
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_DELAY = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic [REG_ADDR_W-1:0] i_rs_addr,
    input  logic [REG_ADDR_W-1:0] i_rt_addr,
    input  logic                  i_uses_rs,
    input  logic                  i_uses_rt,
    input  logic                  i_is_store,
    input  logic                  i_is_jr,
    input  logic                  i_wr_en,
    input  logic [REG_ADDR_W-1:0] i_wr_addr,
    input  logic                  i_is_load,
    input  logic                  i_flush,
    input  logic                  i_hold,
    output logic                  o_stall,
    output logic [1:0]            o_fwd_rs_sel,
    output logic [1:0]            o_fwd_rt_sel,
    output logic                  o_wm_rt_bypass,
    output logic                  o_jr_fwd,
    output logic [CNT_W-1:0]      o_stall_count,
    output logic [CNT_W-1:0]      o_flush_count
);

    localparam logic LD1 = (LOAD_DELAY == 1);
    localparam logic LD2 = (LOAD_DELAY == 2);

    // Writeback needs no shadow entry: the regfile writes before decode reads.
    logic                  r_e_valid, r_e_wr_en, r_e_load;
    logic [REG_ADDR_W-1:0] r_e_addr;
    logic                  r_m_valid, r_m_wr_en, r_m_load;
    logic [REG_ADDR_W-1:0] r_m_addr;
    logic [1:0]            r_rs_sel, r_rt_sel;
    logic                  r_wm_ex, r_wm_mem;

    logic       w_rs_nz, w_rt_nz, w_e_wr, w_m_wr;
    logic       w_e_rs, w_e_rt, w_m_rs, w_m_rt;
    logic       w_stall_a, w_stall_b, w_stall_c, w_stall;
    logic       w_m_fwd_ok, w_wm_nxt;
    logic [1:0] w_rs_sel_nxt, w_rt_sel_nxt;

    assign w_rs_nz = |i_rs_addr;
    assign w_rt_nz = |i_rt_addr;
    assign w_e_wr  = r_e_valid & r_e_wr_en;
    assign w_m_wr  = r_m_valid & r_m_wr_en;

    assign w_e_rs = w_e_wr & (r_e_addr == i_rs_addr) & w_rs_nz;
    assign w_e_rt = w_e_wr & (r_e_addr == i_rt_addr) & w_rt_nz;
    assign w_m_rs = w_m_wr & (r_m_addr == i_rs_addr) & w_rs_nz;
    assign w_m_rt = w_m_wr & (r_m_addr == i_rt_addr) & w_rt_nz;

    // Store data read against a load in EX is covered by the WB->MEM bypass instead.
    assign w_stall_a = r_e_load & ((i_uses_rs & w_e_rs) | (i_uses_rt & ~i_is_store & w_e_rt));
    assign w_stall_b = LD2 & r_m_load & ((i_uses_rs & w_m_rs) | ((i_uses_rt | i_is_store) & w_m_rt));
    assign w_stall_c = i_is_jr & (w_e_rs | (r_m_load & w_m_rs));
    assign w_stall   = i_valid & ~i_flush & ~i_hold & (w_stall_a | w_stall_b | w_stall_c);

    assign w_m_fwd_ok   = ~r_m_load | LD1;
    assign w_rs_sel_nxt = (i_valid & i_uses_rs & w_e_rs)              ? 2'd1 :
                          (i_valid & i_uses_rs & w_m_rs & w_m_fwd_ok) ? 2'd2 : 2'd0;
    assign w_rt_sel_nxt = (i_valid & i_uses_rt & w_e_rt)              ? 2'd1 :
                          (i_valid & i_uses_rt & w_m_rt & w_m_fwd_ok) ? 2'd2 : 2'd0;
    assign w_wm_nxt     = i_valid & i_is_store & r_e_load & w_e_rt & LD1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_e_valid <= 1'b0;
            r_e_wr_en <= 1'b0;
            r_e_load  <= 1'b0;
            r_e_addr  <= '0;
            r_m_valid <= 1'b0;
            r_m_wr_en <= 1'b0;
            r_m_load  <= 1'b0;
            r_m_addr  <= '0;
            r_rs_sel  <= 2'd0;
            r_rt_sel  <= 2'd0;
            r_wm_ex   <= 1'b0;
            r_wm_mem  <= 1'b0;
        end else if (!i_hold) begin
            r_m_valid <= r_e_valid;
            r_m_wr_en <= r_e_wr_en;
            r_m_load  <= r_e_load;
            r_m_addr  <= r_e_addr;
            r_wm_mem  <= r_wm_ex;
            if (i_flush || w_stall) begin
                r_e_valid <= 1'b0;
                r_e_wr_en <= 1'b0;
                r_e_load  <= 1'b0;
                r_e_addr  <= '0;
                r_rs_sel  <= 2'd0;
                r_rt_sel  <= 2'd0;
                r_wm_ex   <= 1'b0;
            end else begin
                r_e_valid <= i_valid;
                r_e_wr_en <= i_wr_en;
                r_e_load  <= i_is_load;
                r_e_addr  <= i_wr_addr;
                r_rs_sel  <= w_rs_sel_nxt;
                r_rt_sel  <= w_rt_sel_nxt;
                r_wm_ex   <= w_wm_nxt;
            end
        end
    end

    assign o_stall        = w_stall;
    assign o_fwd_rs_sel   = r_rs_sel;
    assign o_fwd_rt_sel   = r_rt_sel;
    assign o_wm_rt_bypass = r_wm_mem;
    assign o_jr_fwd       = i_valid & i_is_jr & w_m_rs & ~r_m_load & ~w_stall;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (i_flush && !i_hold && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign o_stall_count = r_stall_cnt;
    assign o_flush_count = r_flush_cnt;
`else
    assign o_stall_count = '0;
    assign o_flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - directed self-checking bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_valid, i_uses_rs, i_uses_rt, i_is_store, i_is_jr, i_wr_en, i_is_load;
    logic        i_flush, i_hold;
    logic [4:0]  i_rs_addr, i_rt_addr, i_wr_addr;
    logic        o_stall, o_wm_rt_bypass, o_jr_fwd;
    logic [1:0]  o_fwd_rs_sel, o_fwd_rt_sel;
    logic [31:0] o_stall_count, o_flush_count;
    logic        d2_stall, d2_wm, d2_jr;
    logic [1:0]  d2_rs_sel, d2_rt_sel;
    logic [31:0] d2_stall_count, d2_flush_count;

    int total = 0;
    int bad   = 0;

`ifdef HAZARD_PERF_EN
    localparam int EXP_STALLS  = 3;
    localparam int EXP_FLUSHES = 2;
`else
    localparam int EXP_STALLS  = 0;
    localparam int EXP_FLUSHES = 0;
`endif

    always #5 clock = ~clock;

    hazard_scoreboard_unit #(.REG_ADDR_W(5), .LOAD_DELAY(1), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .i_valid(i_valid),
        .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
        .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt), .i_is_store(i_is_store),
        .i_is_jr(i_is_jr), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_is_load(i_is_load), .i_flush(i_flush), .i_hold(i_hold),
        .o_stall(o_stall), .o_fwd_rs_sel(o_fwd_rs_sel), .o_fwd_rt_sel(o_fwd_rt_sel),
        .o_wm_rt_bypass(o_wm_rt_bypass), .o_jr_fwd(o_jr_fwd),
        .o_stall_count(o_stall_count), .o_flush_count(o_flush_count)
    );

    hazard_scoreboard_unit #(.REG_ADDR_W(5), .LOAD_DELAY(2), .CNT_W(32)) dut2 (
        .clock(clock), .reset(reset), .i_valid(i_valid),
        .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
        .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt), .i_is_store(i_is_store),
        .i_is_jr(i_is_jr), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_is_load(i_is_load), .i_flush(i_flush), .i_hold(i_hold),
        .o_stall(d2_stall), .o_fwd_rs_sel(d2_rs_sel), .o_fwd_rt_sel(d2_rt_sel),
        .o_wm_rt_bypass(d2_wm), .o_jr_fwd(d2_jr),
        .o_stall_count(d2_stall_count), .o_flush_count(d2_flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic st, input logic jr,
                         input logic we, input logic [4:0] wa, input logic ld);
        i_valid    = v;
        i_rs_addr  = rs;
        i_rt_addr  = rt;
        i_uses_rs  = urs;
        i_uses_rt  = urt;
        i_is_store = st;
        i_is_jr    = jr;
        i_wr_en    = we;
        i_wr_addr  = wa;
        i_is_load  = ld;
        #1;
    endtask

    task automatic nop();
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        i_flush = 1'b0;
        i_hold  = 1'b0;
        nop();
        step();
        step();
        chk("rst_stall", o_stall, 0);
        chk("rst_rs_sel", o_fwd_rs_sel, 0);
        chk("rst_rt_sel", o_fwd_rt_sel, 0);
        chk("rst_wm", o_wm_rt_bypass, 0);
        chk("rst_jr", o_jr_fwd, 0);
        chk("rst_scnt", o_stall_count, 0);
        reset = 1'b0;

        // lw $2 ; add $3,$2,$4
        instr(1, 1, 0, 1, 0, 0, 0, 1, 2, 1);
        chk("lw_nostall", o_stall, 0);
        step();
        instr(1, 2, 4, 1, 1, 0, 0, 1, 3, 0);
        chk("lu_stall1", o_stall, 1);
        chk("lu_stall1_d2", d2_stall, 1);
        step();
        chk("lu_resume", o_stall, 0);
        chk("lu_stall2_d2", d2_stall, 1);
        step();
        chk("lu_rs_sel", o_fwd_rs_sel, 2);
        chk("lu_rt_sel", o_fwd_rt_sel, 0);
        chk("lu_resume_d2", d2_stall, 0);
        step();
        chk("lu_rs_sel_d2", d2_rs_sel, 0);
        nop();
        step();
        step();

        // add $5 ; sub $6,$5,$5
        instr(1, 1, 1, 1, 1, 0, 0, 1, 5, 0);
        step();
        instr(1, 5, 5, 1, 1, 0, 0, 1, 6, 0);
        chk("ex_nostall", o_stall, 0);
        step();
        chk("ex_rs_sel", o_fwd_rs_sel, 1);
        chk("ex_rt_sel", o_fwd_rt_sel, 1);

        // add $5 ; nop ; sub $6,$5,$5
        instr(1, 1, 1, 1, 1, 0, 0, 1, 5, 0);
        step();
        nop();
        step();
        instr(1, 5, 5, 1, 1, 0, 0, 1, 6, 0);
        chk("mem_nostall", o_stall, 0);
        step();
        chk("mem_rs_sel", o_fwd_rs_sel, 2);
        chk("mem_rt_sel", o_fwd_rt_sel, 2);

        // lw $7 ; sw $7,0($8)
        instr(1, 1, 0, 1, 0, 0, 0, 1, 7, 1);
        step();
        instr(1, 8, 7, 1, 0, 1, 0, 0, 0, 0);
        chk("st_nostall", o_stall, 0);
        step();
        chk("st_wm_ex", o_wm_rt_bypass, 0);
        nop();
        step();
        chk("st_wm_mem", o_wm_rt_bypass, 1);
        step();
        chk("st_wm_after", o_wm_rt_bypass, 0);

        // add $9 ; jr $9
        instr(1, 1, 1, 1, 1, 0, 0, 1, 9, 0);
        step();
        instr(1, 9, 0, 1, 0, 0, 1, 0, 0, 0);
        chk("jr_stall", o_stall, 1);
        chk("jr_fwd_early", o_jr_fwd, 0);
        step();
        chk("jr_resume", o_stall, 0);
        chk("jr_fwd", o_jr_fwd, 1);
        step();

        // lw $0 ; add $3,$0,$0
        instr(1, 1, 0, 1, 0, 0, 0, 1, 0, 1);
        step();
        instr(1, 0, 0, 1, 1, 0, 0, 1, 3, 0);
        chk("r0_nostall", o_stall, 0);
        step();
        chk("r0_rs_sel", o_fwd_rs_sel, 0);
        chk("r0_rt_sel", o_fwd_rt_sel, 0);

        // hold in the middle of a load-use stall
        nop();
        step();
        instr(1, 1, 0, 1, 0, 0, 0, 1, 2, 1);
        step();
        instr(1, 2, 4, 1, 1, 0, 0, 1, 3, 0);
        chk("hold_pre_stall", o_stall, 1);
        i_hold = 1'b1;
        #1;
        chk("hold_mask", o_stall, 0);
        step();
        step();
        step();
        chk("hold_mask3", o_stall, 0);
        i_hold = 1'b0;
        #1;
        chk("hold_resume_stall", o_stall, 1);
        step();
        chk("hold_post", o_stall, 0);
        step();
        chk("hold_rs_sel", o_fwd_rs_sel, 2);

        // flush kills the decode slot
        nop();
        step();
        i_flush = 1'b1;
        instr(1, 1, 1, 1, 1, 0, 0, 1, 10, 0);
        chk("fl_nostall", o_stall, 0);
        step();
        i_flush = 1'b0;
        instr(1, 10, 0, 1, 0, 0, 0, 1, 11, 0);
        chk("fl_bubble_nostall", o_stall, 0);
        step();
        chk("fl_bubble_sel", o_fwd_rs_sel, 0);
        instr(1, 1, 0, 1, 0, 0, 0, 1, 2, 1);
        step();
        i_flush = 1'b1;
        instr(1, 2, 4, 1, 1, 0, 0, 1, 3, 0);
        chk("fl_masks_stall", o_stall, 0);
        step();
        i_flush = 1'b0;
        chk("perf_stalls", o_stall_count, EXP_STALLS);
        chk("perf_flushes", o_flush_count, EXP_FLUSHES);

        // reset asserted mid-stall
        nop();
        step();
        instr(1, 1, 0, 1, 0, 0, 0, 1, 2, 1);
        step();
        instr(1, 2, 4, 1, 1, 0, 0, 1, 3, 0);
        chk("rs_pre_stall", o_stall, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("rs_mid_stall", o_stall, 0);
        chk("rs_mid_rs_sel", o_fwd_rs_sel, 0);
        chk("rs_mid_wm", o_wm_rt_bypass, 0);
        chk("rs_mid_scnt", o_stall_count, 0);
        chk("rs_mid_fcnt", o_flush_count, 0);
        step();
        reset = 1'b0;
        #1;
        chk("rs_after", o_stall, 0);
        nop();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
